press_key_overlay: RTL and testbench
====================================

PRESS_KEY_OVERLAY -- requirements
Module: press_key_overlay

Interface
REQ-001 SHALL have parameter H_ORIGIN, default 112, meaning left pixel column of the text window.
REQ-002 SHALL have parameter V_ORIGIN, default 300, meaning top pixel row of the text window.
REQ-003 SHALL have parameter SCALE_SHIFT, default 1, meaning glyph magnification of 2^SCALE_SHIFT in both axes.
REQ-004 SHALL have parameter TEXT_W, default 208, meaning bitmap width in bitmap pixels.
REQ-005 SHALL have parameter TEXT_H, default 16, meaning bitmap height in bitmap pixels.
REQ-006 SHALL have parameter BLINK_FRAMES, default 30, meaning frames per blink half-period.
REQ-007 SHALL have parameter FG_COLOR, default 16'hFFFF, meaning RGB565 text colour.
REQ-008 SHALL have port vga_clk, input, 1 bit, meaning pixel clock; the only clock.
REQ-009 SHALL have port sys_rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-010 SHALL have port pix_x, input, 10 bits, meaning current pixel column.
REQ-011 SHALL have port pix_y, input, 10 bits, meaning current pixel row.
REQ-012 SHALL have port pix_valid, input, 1 bit, meaning active-video qualifier for pix_x, pix_y and bg_data.
REQ-013 SHALL have port frame_start, input, 1 bit, meaning one-cycle pulse at the start of each frame.
REQ-014 SHALL have port bg_data, input, 16 bits, meaning background RGB565, aligned with pix_x and pix_y.
REQ-015 SHALL have port enable, input, 1 bit, meaning request to show the prompt.
REQ-016 SHALL have port key_pulse, input, 1 bit, meaning one-cycle key-press event.
REQ-017 SHALL have port letter_x, output, 8 bits, meaning bit index to the bitmap ROM.
REQ-018 SHALL have port letter_y, output, 8 bits, meaning row index to the bitmap ROM.
REQ-019 SHALL have port letter_bit, input, 1 bit, meaning combinational ROM pixel for the current letter_x and letter_y.
REQ-020 SHALL have port pix_data, output, 16 bits, meaning composited RGB565.
REQ-021 SHALL have port pix_data_valid, output, 1 bit, meaning pix_valid delayed to align with pix_data.
REQ-022 SHALL have port key_ack, output, 1 bit, meaning one-cycle pulse when the prompt is dismissed.

Function
REQ-023 SHALL compute dx = pix_x - H_ORIGIN and dy = pix_y - V_ORIGIN in stage 0, and assert in_win when 0 <= dx < (TEXT_W << SCALE_SHIFT) and 0 <= dy < (TEXT_H << SCALE_SHIFT), using unsigned compares against the origin with no wrap.
REQ-024 SHALL register, at the stage-1 edge, letter_x = TEXT_W-1-(dx >> SCALE_SHIFT) (leftmost pixel reads the ROM MSB), letter_y = dy >> SCALE_SHIFT, and drive both to 0 when in_win=0 or pix_valid=0.
REQ-025 SHALL register at stage 2: pix_data = FG_COLOR if (in_win_d1 & visible & letter_bit), else bg_data delayed 2 cycles.
REQ-026 SHALL give pix_data and pix_data_valid a fixed latency of 2 cycles from pix_x, pix_y, bg_data and pix_valid.
REQ-027 SHALL use an FSM with states IDLE, SHOW and ACK.
REQ-028 SHALL transition IDLE->SHOW when enable=1, clearing blink_cnt to 0 and setting blink_on=1.
REQ-029 SHALL transition SHOW->ACK on key_pulse=1, with key_ack=1 for exactly that one following cycle.
REQ-030 SHALL transition SHOW->IDLE when enable=0 and key_pulse=0.
REQ-031 SHALL transition ACK->IDLE when enable=0, and SHALL ignore key_pulse in ACK and IDLE.
REQ-032 SHALL, in SHOW, increment blink_cnt on each frame_start, wrap BLINK_FRAMES-1->0 and toggle blink_on on the wrap; blink_cnt and blink_on SHALL hold outside SHOW.
REQ-033 SHALL update visible only on frame_start to (state==SHOW & blink_on & ~key_pulse), so that no frame tears mid-scan.
REQ-034 SHALL handle frame_start coincident with key_pulse as follows: key_pulse wins, visible goes to 0, and the FSM enters ACK.
REQ-035 SHALL size blink_cnt as $clog2(BLINK_FRAMES) bits, saturating never.

Reset
REQ-036 SHALL, while sys_rst_n=0, asynchronously force: state=IDLE, blink_cnt=0, blink_on=1, visible=0, letter_x=0, letter_y=0, pix_data=16'h0000, pix_data_valid=0, key_ack=0, and clear the delay pipeline.
REQ-037 SHALL, on reset asserted mid-frame, drop outputs immediately, and after release show no text until a frame_start occurs in SHOW.

Verification
REQ-038 SHALL be verified by: reset release, enable=1, one frame_start, pix=(112,300), letter_bit=1 -> letter_x=207, letter_y=0 one cycle later; pix_data=16'hFFFF two cycles later.
REQ-039 SHALL be verified by: pix=(111,300) and pix=(528,300) with bg_data=16'h001F -> pix_data=16'h001F and letter_x=0 for both.
REQ-040 SHALL be verified by: pix=(113,331) -> letter_x=207, letter_y=15; pix=(527,300) -> letter_x=0.
REQ-041 SHALL be verified by: SHOW for 60 frame_starts -> visible 1 for frames 1-30 and 0 for frames 31-60, with the toggle exactly on the 30th frame_start.
REQ-042 SHALL be verified by: key_pulse coincident with frame_start in SHOW -> key_ack one cycle, state ACK, and bg_data passes through on the next frame; a second key_pulse produces no key_ack.
REQ-043 SHALL be verified by: sys_rst_n low mid-line while pix_data=16'hFFFF -> pix_data=0 without a clock edge, and state=IDLE after release.

Source files
------------

// File: rtl/press_key_overlay.sv
// Blinking "press key" text overlay on an RGB565 pixel stream; 2-cycle pixel latency, no backpressure.
// Prompt blinks per frame while shown and is dismissed by a key press, acknowledged with a one-cycle key_ack.
module press_key_overlay #(
  parameter int          H_ORIGIN     = 112,
  parameter int          V_ORIGIN     = 300,
  parameter int          SCALE_SHIFT  = 1,
  parameter int          TEXT_W       = 208,
  parameter int          TEXT_H       = 16,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [15:0] FG_COLOR     = 16'hFFFF
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        pix_valid,
  input  logic        frame_start,
  input  logic [15:0] bg_data,
  input  logic        enable,
  input  logic        key_pulse,
  output logic [7:0]  letter_x,
  output logic [7:0]  letter_y,
  input  logic        letter_bit,
  output logic [15:0] pix_data,
  output logic        pix_data_valid,
  output logic        key_ack
);

  localparam int WIN_W = TEXT_W << SCALE_SHIFT;
  localparam int WIN_H = TEXT_H << SCALE_SHIFT;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_on;
  logic             visible;
  logic             enter_show;
  logic             in_show;
  logic             ack_set;

  // Stage 0: window test and bitmap coordinates
  logic [10:0] dx;
  logic [10:0] dy;
  logic        in_win;
  logic [7:0]  col;
  logic [7:0]  row;

  always_comb begin
    dx     = {1'b0, pix_x} - 11'(H_ORIGIN);
    dy     = {1'b0, pix_y} - 11'(V_ORIGIN);
    in_win = ({1'b0, pix_x} >= 11'(H_ORIGIN)) && (dx < 11'(WIN_W)) &&
             ({1'b0, pix_y} >= 11'(V_ORIGIN)) && (dy < 11'(WIN_H));
    col    = 8'(TEXT_W - 1) - 8'(dx >> SCALE_SHIFT);
    row    = 8'(dy >> SCALE_SHIFT);
  end

  logic        in_win_d1;
  logic [15:0] bg_d1;
  logic        valid_d1;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      letter_x       <= 8'd0;
      letter_y       <= 8'd0;
      in_win_d1      <= 1'b0;
      bg_d1          <= 16'h0000;
      valid_d1       <= 1'b0;
      pix_data       <= 16'h0000;
      pix_data_valid <= 1'b0;
    end else begin
      if (in_win && pix_valid) begin
        letter_x <= col;
        letter_y <= row;
      end else begin
        letter_x <= 8'd0;
        letter_y <= 8'd0;
      end
      in_win_d1      <= in_win & pix_valid;
      bg_d1          <= bg_data;
      valid_d1       <= pix_valid;
      // letter_bit answers the letter_x/letter_y registered on the previous edge
      pix_data       <= (in_win_d1 && visible && letter_bit) ? FG_COLOR : bg_d1;
      pix_data_valid <= valid_d1;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable) state_nxt = SHOW;
      SHOW: begin
        if (key_pulse)    state_nxt = ACK;
        else if (!enable) state_nxt = IDLE;
      end
      ACK:  if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    enter_show = (state == IDLE) && enable;
    in_show    = (state == SHOW);
    ack_set    = (state == SHOW) && key_pulse;
  end

  // Visibility latches only at frame boundaries so a frame never tears
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      visible   <= 1'b0;
      key_ack   <= 1'b0;
    end else begin
      if (enter_show) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (in_show && frame_start) begin
        if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + CNT_W'(1);
        end
      end
      if (frame_start) visible <= in_show & blink_on & ~key_pulse;
      key_ack <= ack_set;
    end
  end

endmodule

// File: tb/tb_press_key_overlay.sv
// Directed bench for press_key_overlay: vector table for window mapping plus blink, key and reset sequences.
module tb_press_key_overlay;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic        pix_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [15:0] bg_data = '0;
  logic        enable = 1'b0;
  logic        key_pulse = 1'b0;
  logic        letter_bit = 1'b0;
  logic [7:0]  letter_x;
  logic [7:0]  letter_y;
  logic [15:0] pix_data;
  logic        pix_data_valid;
  logic        key_ack;

  press_key_overlay dut (
    .vga_clk        (vga_clk),
    .sys_rst_n      (sys_rst_n),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .pix_valid      (pix_valid),
    .frame_start    (frame_start),
    .bg_data        (bg_data),
    .enable         (enable),
    .key_pulse      (key_pulse),
    .letter_x       (letter_x),
    .letter_y       (letter_y),
    .letter_bit     (letter_bit),
    .pix_data       (pix_data),
    .pix_data_valid (pix_data_valid),
    .key_ack        (key_ack)
  );

  always #5 vga_clk = ~vga_clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        vld;
    logic [15:0] bg;
    logic        lb;
    logic [7:0]  elx;
    logic [7:0]  ely;
    logic [15:0] epd;
    logic        epv;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic [15:0] bg,
                       input logic lb, output logic [15:0] pd);
    pix_x = x; pix_y = y; bg_data = bg; letter_bit = lb; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    tick();
    pd = pix_data;
  endtask

  logic [15:0] pd;

  initial begin
    vt[0] = '{10'd112, 10'd300, 1'b1, 16'h001F, 1'b1, 8'd207, 8'd0,  16'hFFFF, 1'b1};
    vt[1] = '{10'd111, 10'd300, 1'b1, 16'h001F, 1'b1, 8'd0,   8'd0,  16'h001F, 1'b1};
    vt[2] = '{10'd528, 10'd300, 1'b1, 16'h001F, 1'b1, 8'd0,   8'd0,  16'h001F, 1'b1};
    vt[3] = '{10'd113, 10'd331, 1'b1, 16'h001F, 1'b1, 8'd207, 8'd15, 16'hFFFF, 1'b1};
    vt[4] = '{10'd527, 10'd300, 1'b1, 16'h001F, 1'b1, 8'd0,   8'd0,  16'hFFFF, 1'b1};
    vt[5] = '{10'd112, 10'd300, 1'b1, 16'h1234, 1'b0, 8'd207, 8'd0,  16'h1234, 1'b1};
    vt[6] = '{10'd200, 10'd310, 1'b1, 16'h4321, 1'b1, 8'd163, 8'd5,  16'hFFFF, 1'b1};
    vt[7] = '{10'd200, 10'd332, 1'b1, 16'hABCD, 1'b1, 8'd0,   8'd0,  16'hABCD, 1'b1};
    vt[8] = '{10'd200, 10'd299, 1'b1, 16'hBEEF, 1'b1, 8'd0,   8'd0,  16'hBEEF, 1'b1};
    vt[9] = '{10'd112, 10'd300, 1'b0, 16'h5555, 1'b1, 8'd0,   8'd0,  16'h5555, 1'b0};

    // Reset state
    #12;
    chk("rst_pix_data", 32'(pix_data), 32'h0);
    chk("rst_pix_valid", 32'(pix_data_valid), 32'h0);
    chk("rst_key_ack", 32'(key_ack), 32'h0);
    chk("rst_letter_x", 32'(letter_x), 32'h0);
    chk("rst_letter_y", 32'(letter_y), 32'h0);
    sys_rst_n = 1'b1;
    tick();

    // Enter SHOW; nothing drawn until a frame_start
    enable = 1'b1;
    tick();
    probe(10'd112, 10'd300, 16'h001F, 1'b1, pd);
    chk("show_before_frame", 32'(pd), 32'h001F);
    pulse_frame();

    foreach (vt[i]) begin
      pix_x = vt[i].x; pix_y = vt[i].y; pix_valid = vt[i].vld;
      bg_data = vt[i].bg; letter_bit = vt[i].lb;
      tick();
      chk($sformatf("vec%0d_letter_x", i), 32'(letter_x), 32'(vt[i].elx));
      chk($sformatf("vec%0d_letter_y", i), 32'(letter_y), 32'(vt[i].ely));
      pix_valid = 1'b0;
      tick();
      chk($sformatf("vec%0d_pix_data", i), 32'(pix_data), 32'(vt[i].epd));
      chk($sformatf("vec%0d_pix_valid", i), 32'(pix_data_valid), 32'(vt[i].epv));
    end

    // Blink: restart SHOW so the counter is fresh, then walk 61 frames
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    for (int f = 1; f <= 61; f++) begin
      pulse_frame();
      probe(10'd112, 10'd300, 16'h07E0, 1'b1, pd);
      chk($sformatf("blink_frame%0d", f), 32'(pd),
          (f <= 30 || f == 61) ? 32'hFFFF : 32'h07E0);
    end

    // Key press coincident with frame_start
    frame_start = 1'b1;
    key_pulse = 1'b1;
    tick();
    frame_start = 1'b0;
    key_pulse = 1'b0;
    chk("key_ack_pulse", 32'(key_ack), 32'h1);
    tick();
    chk("key_ack_one_cycle", 32'(key_ack), 32'h0);
    chk("state_ack", 32'(dut.state), 32'd2);
    probe(10'd112, 10'd300, 16'hF800, 1'b1, pd);
    chk("hidden_after_key", 32'(pd), 32'hF800);
    pulse_frame();
    probe(10'd112, 10'd300, 16'hF81F, 1'b1, pd);
    chk("bg_next_frame", 32'(pd), 32'hF81F);
    key_pulse = 1'b1;
    tick();
    key_pulse = 1'b0;
    chk("second_key_no_ack", 32'(key_ack), 32'h0);
    tick();
    chk("second_key_no_ack_late", 32'(key_ack), 32'h0);

    // Reset mid-line while text is being drawn
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    pulse_frame();
    pix_x = 10'd112; pix_y = 10'd300; bg_data = 16'h001F; letter_bit = 1'b1; pix_valid = 1'b1;
    tick();
    tick();
    chk("pre_reset_text", 32'(pix_data), 32'hFFFF);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("async_rst_pix_data", 32'(pix_data), 32'h0);
    chk("async_rst_pix_valid", 32'(pix_data_valid), 32'h0);
    chk("async_rst_letter_x", 32'(letter_x), 32'h0);
    enable = 1'b0;
    pix_valid = 1'b0;
    #10;
    sys_rst_n = 1'b1;
    tick();
    chk("state_idle_after_rst", 32'(dut.state), 32'd0);
    enable = 1'b1;
    tick();
    probe(10'd112, 10'd300, 16'h001F, 1'b1, pd);
    chk("no_text_before_frame", 32'(pd), 32'h001F);
    pulse_frame();
    probe(10'd112, 10'd300, 16'h001F, 1'b1, pd);
    chk("text_after_frame", 32'(pd), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
